// File: rtl/axi4_read_test_if.sv
// axi4_ifc: read half of an AXI4 bus (AR and R channels).
//
// The write channels belong to other masters and are carried on their own bundles.
//
// Parameters:
//   IWIDTH  width of arid/rid
// Modports:
//   master  drives AR channel and rready; receives arready and the R channel
//   slave   the mirror image
interface axi4_ifc #(
  parameter int unsigned IWIDTH = 4
);
  // AR channel
  logic [IWIDTH-1:0] arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  // R channel
  logic [IWIDTH-1:0] rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_read_test.sv
// axi4_read_test: self-checking AXI4 read initiator.
//
// On an accepted start it reads BURSTS INCR bursts of BEATS 32-bit words starting at BASE and
// checks every beat against the address-derived pattern (A ^ PATTERN), the expected rlast and
// the expected rid. Mismatches set a sticky error; the run always completes and raises done.
//
// Parameters:
//   BASE     byte address of the first burst (4-byte aligned)
//   BEATS    beats per burst, 1..16
//   BURSTS   bursts per run, 1..256
//   IWIDTH   id width, must match the bus
//   ARID     value driven on arid and expected on rid
//   PATTERN  XOR key for the expected data
// Ports:
//   clk      clock, everything on posedge
//   reset    synchronous active-high reset
//   start    one-cycle run request, ignored while a run is in flight
//   done     high from run completion until the next accepted start or reset
//   error    sticky mismatch flag, cleared by an accepted start or reset
//   m        AXI4 master (AR channel and rready only)
// Build option:
//   AXI4_READ_TEST_RRESP_CHECK_EN  when defined, a non-OKAY rresp on any beat also sets error
module axi4_read_test #(
  parameter logic [31:0] BASE    = 32'h0,
  parameter int unsigned BEATS   = 8,
  parameter int unsigned BURSTS  = 4,
  parameter int unsigned IWIDTH  = 4,
  parameter int unsigned ARID    = 0,
  parameter logic [31:0] PATTERN = 32'h1234_5678
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  output logic    done,
  output logic    error,
  axi4_ifc.master m
);

  localparam logic [7:0]        ArLen     = 8'(BEATS - 1);
  localparam logic [4:0]        LastBeat  = 5'(BEATS - 1);
  localparam logic [8:0]        LastBurst = 9'(BURSTS - 1);
  localparam logic [IWIDTH-1:0] ArId      = IWIDTH'(ARID);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StFin} state_e;

  state_e      state_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        done_q;
  logic        error_q;
  logic [31:0] addr_q;   // address of the next beat; doubles as araddr while in StAddr
  logic [4:0]  beat_q;
  logic [8:0]  burst_q;

  logic r_hs;
  logic last_beat;
  logic last_burst;
  logic rdata_bad;
  logic rlast_bad;
  logic rid_bad;
  logic rresp_bad;
  logic beat_bad;

`ifdef AXI4_READ_TEST_RRESP_CHECK_EN
  assign rresp_bad = (m.rresp != 2'b00);
`else
  logic unused_rresp;
  assign unused_rresp = ^m.rresp;
  assign rresp_bad    = 1'b0;
`endif

  always_comb begin
    r_hs       = m.rvalid & rready_q;
    last_beat  = (beat_q == LastBeat);
    last_burst = (burst_q == LastBurst);
    rdata_bad  = (m.rdata != (addr_q ^ PATTERN));
    rlast_bad  = (m.rlast != last_beat);
    rid_bad    = (m.rid != ArId);
    beat_bad   = rdata_bad | rlast_bad | rid_bad | rresp_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      addr_q    <= BASE;
      beat_q    <= '0;
      burst_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StFin: begin
          if (start) begin
            state_q   <= StAddr;
            arvalid_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            addr_q    <= BASE;
            beat_q    <= '0;
            burst_q   <= '0;
          end
        end
        StAddr: begin
          if (m.arready) begin
            state_q   <= StData;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
          end
        end
        StData: begin
          if (r_hs) begin
            error_q <= error_q | beat_bad;
            addr_q  <= addr_q + 32'd4;
            beat_q  <= beat_q + 5'd1;
            if (last_beat) begin
              rready_q <= 1'b0;
              if (last_burst) begin
                state_q <= StFin;
                done_q  <= 1'b1;
              end else begin
                // addr_q already advances to the next burst's first word on this edge
                state_q   <= StAddr;
                arvalid_q <= 1'b1;
                burst_q   <= burst_q + 9'd1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m.arid    = ArId;
  assign m.araddr  = addr_q;
  assign m.arlen   = ArLen;
  assign m.arsize  = 3'd2;
  assign m.arburst = 2'b01;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arvalid = arvalid_q;
  assign m.rready  = rready_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_axi4_read_test.sv
// Bench for axi4_read_test: a randomised behavioural AXI4 read slave with fault injection,
// a reference model of the expected error flag / AR address sequence, and per-beat checks of
// the sticky error and done flags.
module tb_axi4_read_test;

  localparam logic [31:0] Base   = 32'h0;
  localparam int unsigned Beats  = 8;
  localparam int unsigned Bursts = 4;
  localparam int unsigned Total  = Beats * Bursts;
  localparam logic [3:0]  ArId   = 4'd3;
  localparam logic [31:0] Pat    = 32'h1234_5678;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;
  logic error;

  axi4_ifc #(.IWIDTH(4)) bus ();

  axi4_read_test #(
    .BASE    (Base),
    .BEATS   (Beats),
    .BURSTS  (Bursts),
    .IWIDTH  (4),
    .ARID    (int'(ArId)),
    .PATTERN (Pat)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done),
    .error (error),
    .m     (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fault-injection knobs, written by the main thread only between runs
  logic        corrupt_en;
  logic [31:0] corrupt_addr;
  logic        early_en;
  int unsigned early_burst;
  logic        rid_en;
  int unsigned rid_beat;
  logic        rresp_en;
  int unsigned rresp_beat;
  int unsigned stall_req;
  logic        busy_start;

  task automatic clear_knobs();
    corrupt_en = 0; corrupt_addr = '0; early_en = 0; early_burst = 0;
    rid_en = 0; rid_beat = 0; rresp_en = 0; rresp_beat = 0; stall_req = 0; busy_start = 0;
  endtask

  // Reference model: will this run end with error set?
  function automatic logic model_err();
    logic e = 1'b0;
    if (corrupt_en && corrupt_addr >= Base && corrupt_addr < Base + Total * 4) e = 1'b1;
    if (early_en && early_burst < Bursts) e = 1'b1;
    if (rid_en && rid_beat < Total) e = 1'b1;
`ifdef AXI4_READ_TEST_RRESP_CHECK_EN
    if (rresp_en && rresp_beat < Total) e = 1'b1;
`endif
    return e;
  endfunction

  // Slave / monitor state
  logic [31:0] ar_log[$];
  int unsigned wait_log[$];
  int unsigned g_beat;
  logic        err_sofar;
  logic        act;
  logic [31:0] cur_addr;
  int unsigned cur_beat;
  int unsigned cur_len;
  int unsigned sl_wait;
  logic        p_ar, p_r, beat_fault;
  logic        hold_arvalid;
  logic [31:0] hold_araddr;
  logic [7:0]  hold_arlen;
  logic [2:0]  hold_arsize, hold_arprot;
  logic [1:0]  hold_arburst;
  logic [3:0]  hold_arid, hold_arcache;

  // Slave steps 1 time unit after each posedge: first resolve the handshakes that happened on
  // that edge (using values held since the previous step), then drive the next cycle.
  initial begin
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0;
    bus.rid = '0;
    act = 0; p_ar = 0; p_r = 0; beat_fault = 0; sl_wait = 0; hold_arvalid = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        act = 0; sl_wait = 0;
      end else begin
        if (p_ar) begin
          check_eq("araddr_seq", hold_araddr, Base + ar_log.size() * Beats * 4);
          check_eq("arlen", {24'h0, hold_arlen}, Beats - 1);
          check_eq("ar_fields", {hold_arsize, hold_arburst, hold_arid, hold_arcache, hold_arprot},
                   {3'd2, 2'b01, ArId, 4'd0, 3'd0});
          check_eq("ar_drop_rready", {bus.arvalid, bus.rready}, 2'b01);
          ar_log.push_back(hold_araddr);
          wait_log.push_back(sl_wait);
          sl_wait = 0;
          act = 1; cur_addr = hold_araddr; cur_beat = 0; cur_len = hold_arlen;
        end else if (hold_arvalid) begin
          sl_wait++;
          check_eq("ar_stable", {bus.arvalid, bus.araddr}, {1'b1, hold_araddr});
        end
        if (p_r) begin
          g_beat++;
          err_sofar = err_sofar | beat_fault;
          check_eq("error_sticky", error, err_sofar);
          check_eq("done_flag", done, g_beat == Total);
          cur_beat++; cur_addr += 4;
          if (cur_beat > cur_len) act = 0;
        end
      end
      // drive next cycle
      if (stall_req > 0) bus.arready = bus.arvalid && sl_wait >= stall_req;
      else bus.arready = $urandom_range(0, 1) == 1;
      if (act && $urandom_range(0, 3) != 0) begin
        bus.rvalid = 1;
        bus.rdata  = (corrupt_en && cur_addr == corrupt_addr) ? 32'h0 : (cur_addr ^ Pat);
        bus.rlast  = (cur_beat == cur_len) ||
                     (early_en && ar_log.size() == early_burst + 1 && cur_beat == 6);
        bus.rid    = (rid_en && g_beat == rid_beat) ? ~ArId : ArId;
        bus.rresp  = (rresp_en && g_beat == rresp_beat) ? 2'b10 : 2'b00;
        beat_fault = (bus.rdata != (cur_addr ^ Pat)) || (bus.rlast != (cur_beat == cur_len)) ||
                     (bus.rid != ArId);
`ifdef AXI4_READ_TEST_RRESP_CHECK_EN
        beat_fault = beat_fault || (bus.rresp != 2'b00);
`endif
      end else begin
        bus.rvalid = 0;
        beat_fault = 0;
      end
      hold_arvalid = bus.arvalid; hold_araddr = bus.araddr; hold_arlen = bus.arlen;
      hold_arsize = bus.arsize; hold_arburst = bus.arburst; hold_arid = bus.arid;
      hold_arcache = bus.arcache; hold_arprot = bus.arprot;
      p_ar = bus.arvalid && bus.arready;
      p_r  = bus.rvalid && bus.rready;
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_run(input string tag);
    ar_log.delete(); wait_log.delete(); g_beat = 0; err_sofar = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    check_eq({tag, "_start"}, {bus.arvalid, done, error}, 3'b100);
  endtask

  task automatic do_run(input string tag);
    int unsigned cyc;
    start_run(tag);
    cyc = 0;
    while (!done && cyc < 2000) begin
      start = busy_start && cyc == 15;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    check_eq({tag, "_in_time"}, cyc < 2000, 1);
    check_eq({tag, "_beats"}, g_beat, Total);
    check_eq({tag, "_bursts"}, ar_log.size(), Bursts);
    for (int i = 0; i < ar_log.size(); i++) check_eq({tag, "_araddr"}, ar_log[i], Base + i * 32);
    check_eq({tag, "_error"}, error, model_err());
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_hold"}, {done, error}, {1'b1, model_err()});
  endtask

  initial begin
    int unsigned cyc;
    reset = 1; start = 0;
    clear_knobs();
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", {bus.arvalid, bus.rready, done, error}, 4'b0000);
    check_eq("reset_araddr", bus.araddr, Base);
    check_eq("reset_arlen", bus.arlen, Beats - 1);
    reset = 0;
    @(negedge clk);

    do_run("clean");
    corrupt_en = 1; corrupt_addr = 32'h14;
    do_run("corrupt14");
    clear_knobs(); early_en = 1; early_burst = 0;
    do_run("early_rlast");
    clear_knobs(); stall_req = 10;
    do_run("ar_stall");
    check_eq("ar_wait", wait_log.size() > 0 ? wait_log[0] : 999, 10);
    clear_knobs(); busy_start = 1;
    do_run("busy_start");
    clear_knobs(); rid_en = 1; rid_beat = $urandom_range(0, Total - 1);
    do_run("bad_rid");
    clear_knobs(); rresp_en = 1; rresp_beat = $urandom_range(0, Total - 1);
    do_run("bad_rresp");
    for (int r = 0; r < 6; r++) begin
      clear_knobs();
      corrupt_en   = $urandom_range(0, 1) == 1;
      corrupt_addr = $urandom_range(0, 63) * 4;  // half the range lies beyond the run
      rid_en       = $urandom_range(0, 3) == 0;
      rid_beat     = $urandom_range(0, Total - 1);
      early_en     = $urandom_range(0, 3) == 0;
      early_burst  = $urandom_range(0, Bursts);
      do_run("random");
    end

    // Reset in the middle of burst 2, then reset and start together, then a clean rerun
    clear_knobs(); corrupt_en = 1; corrupt_addr = Base;
    start_run("mid");
    cyc = 0;
    while (g_beat < 2 * Beats + 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mid_reached", cyc < 2000, 1);
    check_eq("mid_err_before", error, 1);
    reset = 1;
    @(posedge clk);
    #2;
    check_eq("mid_reset_ctl", {bus.arvalid, bus.rready, done, error}, 4'b0000);
    check_eq("mid_reset_araddr", bus.araddr, Base);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #2;
    check_eq("reset_wins", {bus.arvalid, done, error}, 3'b000);
    @(negedge clk);
    reset = 0; start = 0;
    clear_knobs();
    @(negedge clk);
    do_run("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
